// File: rtl/apb_slave_regfile.sv
// APB3 completer register file with a read-only ID register at word 0.
// Optional wait states are enabled with the APB_SLV_WAIT_EN macro.
module apb_slave_regfile #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS = 8,
   parameter logic [DATA_WIDTH-1:0] ID_VALUE = 32'hA9B0_0001,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                           pclk,
   input  logic                           preset,
   input  logic                           pselx,
   input  logic                           penable,
   input  logic                           pwrite,
   input  logic [ADDR_WIDTH-1:0]          paddr,
   input  logic [DATA_WIDTH-1:0]          pwdata,
   output logic                           pready,
   output logic [DATA_WIDTH-1:0]          prdata,
   output logic                           pslverr,
   output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

   localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int AIDX_W = ADDR_WIDTH - 2;

`ifdef APB_SLV_WAIT_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;
   logic [3:0] cnt_reg;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RESP = 2'd2} state_t;
   logic [31:0] unused_wait_cycles;
   assign unused_wait_cycles = 32'(WAIT_CYCLES);
`endif

   state_t state_reg;
   logic [DATA_WIDTH-1:0] regs_reg [NUM_REGS];
   logic                  wr_pend_reg;
   logic [IDX_W-1:0]      wr_idx_reg;
   logic [DATA_WIDTH-1:0] wr_data_reg;

   logic [AIDX_W-1:0]     idx_full;
   logic [IDX_W-1:0]      idx;
   logic                  acc_err;
   logic [DATA_WIDTH-1:0] rd_val;
   logic [DATA_WIDTH-1:0] load_data;
   logic                  commit;

   assign idx_full  = paddr[ADDR_WIDTH-1:2];
   assign idx       = idx_full[IDX_W-1:0];
   assign acc_err   = (paddr[1:0] != 2'b00) || (idx_full >= AIDX_W'(NUM_REGS))
                      || (pwrite && (idx_full == '0));
   assign rd_val    = (idx == '0) ? ID_VALUE : regs_reg[idx];
   assign load_data = (acc_err || pwrite) ? '0 : rd_val;
   assign commit    = (state_reg == S_RESP) && pselx && penable && wr_pend_reg;

   always_ff @(posedge pclk) begin
      if (preset) begin
         state_reg   <= S_IDLE;
         pready      <= 1'b0;
         prdata      <= '0;
         pslverr     <= 1'b0;
         wr_pend_reg <= 1'b0;
         wr_idx_reg  <= '0;
         wr_data_reg <= '0;
`ifdef APB_SLV_WAIT_EN
         cnt_reg     <= '0;
`endif
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (pselx && !penable) begin
`ifdef APB_SLV_WAIT_EN
                  if (WAIT_CYCLES == 0) begin
                     state_reg   <= S_RESP;
                     pready      <= 1'b1;
                     prdata      <= load_data;
                     pslverr     <= acc_err;
                     wr_pend_reg <= pwrite && !acc_err;
                     wr_idx_reg  <= idx;
                     wr_data_reg <= pwdata;
                  end else begin
                     state_reg <= S_WAIT;
                     cnt_reg   <= 4'(WAIT_CYCLES - 1);
                  end
`else
                  state_reg   <= S_RESP;
                  pready      <= 1'b1;
                  prdata      <= load_data;
                  pslverr     <= acc_err;
                  wr_pend_reg <= pwrite && !acc_err;
                  wr_idx_reg  <= idx;
                  wr_data_reg <= pwdata;
`endif
               end
            end
`ifdef APB_SLV_WAIT_EN
            S_WAIT: begin
               // Master dropping select while we stall abandons the transfer.
               if (!pselx) begin
                  state_reg <= S_IDLE;
               end else if (cnt_reg == 4'd0) begin
                  state_reg   <= S_RESP;
                  pready      <= 1'b1;
                  prdata      <= load_data;
                  pslverr     <= acc_err;
                  wr_pend_reg <= pwrite && !acc_err;
                  wr_idx_reg  <= idx;
                  wr_data_reg <= pwdata;
               end else begin
                  cnt_reg <= cnt_reg - 4'd1;
               end
            end
`endif
            S_RESP: begin
               if (pselx && penable) begin
                  state_reg   <= S_IDLE;
                  pready      <= 1'b0;
                  prdata      <= '0;
                  pslverr     <= 1'b0;
                  wr_pend_reg <= 1'b0;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_reg[i] <= '0;
         end
      end else if (commit) begin
         regs_reg[wr_idx_reg] <= wr_data_reg;
      end
   end

   // Word 0 is the constant ID; its storage slot is never written.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_regs_o
         if (gi == 0) begin : g_id
            assign regs_o[0 +: DATA_WIDTH] = ID_VALUE;
         end else begin : g_rw
            assign regs_o[gi*DATA_WIDTH +: DATA_WIDTH] = regs_reg[gi];
         end
      end
   endgenerate

endmodule
